// File: rtl/pit_channel_ctrl.sv
// One 8254-style timer channel: control-word decode, count assembly, load/hold sequencing,
// OUT for modes 0 and 2, and count reads. Define PIT_COUNT_LATCH_EN to add the RW=00 counter-latch command.
module pit_channel_ctrl #(
   parameter int CHANNEL_ID = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr,
   input  logic        rd,
   input  logic [1:0]  addr,
   input  logic [7:0]  d_in,
   output logic [7:0]  d_out,
   input  logic        gate,
   input  logic [15:0] cnt_value,
   input  logic        cnt_done,
   output logic [15:0] new_count,
   output logic        load,
   output logic        cnt_hold,
   output logic        out
);
   localparam logic [1:0] CH = 2'(CHANNEL_ID);

   typedef enum logic [1:0] {IDLE, WAIT_LSB, WAIT_MSB, RUNNING} state_t;

   state_t      state_reg, state_next;
   logic [1:0]  rw_reg, rw_next;
   logic        mode2_reg, mode2_next;
   logic        wr_byte_reg, wr_byte_next;
   logic        m0_hold_reg, m0_hold_next;
   logic [7:0]  lsb_reg, lsb_next;
   logic [15:0] new_count_reg, new_count_next;
   logic        load_reg, load_next;
   logic        last_load_reg;
   logic        out_reg, out_next;
   logic        rd_byte_reg, rd_byte_next;
   logic [7:0]  d_out_reg, d_out_next;
`ifdef PIT_COUNT_LATCH_EN
   logic [15:0] latch_reg, latch_next;
   logic        latched_reg, latched_next;
`endif

   logic        running, done_ok, reload, ctrl_hit, data_wr, data_rd, msb_phase, complete;
   logic [15:0] wr_value, rd_src;

   assign running   = (state_reg == RUNNING);
   // Terminal count is ignored in a load cycle, when cnt_done still reflects the old count.
   assign done_ok   = running & cnt_done & ~load_reg;
   // Blocking the cycle right after a load makes a zero count reload every 2 clocks.
   assign reload    = done_ok & mode2_reg & ~last_load_reg;
   assign load      = load_reg | reload;
   assign cnt_hold  = !running ? 1'b1 : (load ? 1'b0 : (m0_hold_reg | ~gate));
   assign out       = mode2_reg ? (out_reg & ~reload) : (out_reg | done_ok);
   assign new_count = new_count_reg;
   assign d_out     = d_out_reg;

   assign ctrl_hit  = wr & (addr == 2'b11) & (d_in[7:6] == CH);
   assign data_wr   = wr & (addr == CH) & (state_reg != IDLE);
   assign data_rd   = rd & ~wr & (addr == CH);
   assign msb_phase = (state_reg == WAIT_MSB) | (running & wr_byte_reg);
   assign complete  = (rw_reg != 2'b11) | msb_phase;

`ifdef PIT_COUNT_LATCH_EN
   assign rd_src = latched_reg ? latch_reg : cnt_value;
`else
   assign rd_src = cnt_value;
`endif

   always_comb begin
      case (rw_reg)
         2'b01:   wr_value = {8'h00, d_in};
         2'b10:   wr_value = {d_in, 8'h00};
         default: wr_value = {d_in, lsb_reg};
      endcase
   end

   always_comb begin
      state_next     = state_reg;
      rw_next        = rw_reg;
      mode2_next     = mode2_reg;
      wr_byte_next   = wr_byte_reg;
      m0_hold_next   = m0_hold_reg;
      lsb_next       = lsb_reg;
      new_count_next = new_count_reg;
      load_next      = 1'b0;
      out_next       = out_reg;
      rd_byte_next   = rd_byte_reg;
      d_out_next     = d_out_reg;
`ifdef PIT_COUNT_LATCH_EN
      latch_next     = latch_reg;
      latched_next   = latched_reg;
`endif
      if (!mode2_reg && done_ok)
         out_next = 1'b1;

      if (ctrl_hit) begin
         if (d_in[5:4] == 2'b00) begin
`ifdef PIT_COUNT_LATCH_EN
            if (!latched_reg) begin
               latch_next   = cnt_value;
               latched_next = 1'b1;
            end
`endif
         end else begin
            rw_next      = d_in[5:4];
            mode2_next   = (d_in[2:1] == 2'b10);
            state_next   = (d_in[5:4] == 2'b10) ? WAIT_MSB : WAIT_LSB;
            wr_byte_next = 1'b0;
            m0_hold_next = 1'b0;
            rd_byte_next = 1'b0;
            out_next     = (d_in[2:1] == 2'b10);
         end
      end else if (data_wr) begin
         if (complete) begin
            new_count_next = wr_value;
            wr_byte_next   = 1'b0;
            m0_hold_next   = 1'b0;
            // A running mode-2 channel picks up the new count at its next reload instead.
            if (!(running && mode2_reg)) begin
               load_next  = 1'b1;
               state_next = RUNNING;
               if (!mode2_reg)
                  out_next = 1'b0;
            end
         end else begin
            lsb_next = d_in;
            if (running) begin
               wr_byte_next = 1'b1;
               m0_hold_next = ~mode2_reg;
            end else begin
               state_next = WAIT_MSB;
            end
         end
      end

      if (data_rd) begin
         case (rw_reg)
            2'b10:   d_out_next = rd_src[15:8];
            2'b11:   d_out_next = rd_byte_reg ? rd_src[15:8] : rd_src[7:0];
            default: d_out_next = rd_src[7:0];
         endcase
         if (rw_reg == 2'b11)
            rd_byte_next = ~rd_byte_reg;
`ifdef PIT_COUNT_LATCH_EN
         if (latched_reg && (rw_reg != 2'b11 || rd_byte_reg))
            latched_next = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         rw_reg        <= 2'b00;
         mode2_reg     <= 1'b0;
         wr_byte_reg   <= 1'b0;
         m0_hold_reg   <= 1'b0;
         lsb_reg       <= 8'h00;
         new_count_reg <= 16'h0000;
         load_reg      <= 1'b0;
         last_load_reg <= 1'b0;
         out_reg       <= 1'b0;
         rd_byte_reg   <= 1'b0;
         d_out_reg     <= 8'h00;
`ifdef PIT_COUNT_LATCH_EN
         latch_reg     <= 16'h0000;
         latched_reg   <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         rw_reg        <= rw_next;
         mode2_reg     <= mode2_next;
         wr_byte_reg   <= wr_byte_next;
         m0_hold_reg   <= m0_hold_next;
         lsb_reg       <= lsb_next;
         new_count_reg <= new_count_next;
         load_reg      <= load_next;
         last_load_reg <= load;
         out_reg       <= out_next;
         rd_byte_reg   <= rd_byte_next;
         d_out_reg     <= d_out_next;
`ifdef PIT_COUNT_LATCH_EN
         latch_reg     <= latch_next;
         latched_reg   <= latched_next;
`endif
      end
   end
endmodule

// File: tb/tb_pit_channel_ctrl.sv
// Directed bench for pit_channel_ctrl (channel 0) with a behavioural down-counter attached.
module tb_pit_channel_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr = 1'b0;
   logic        rd = 1'b0;
   logic [1:0]  addr = 2'b00;
   logic [7:0]  d_in = 8'h00;
   logic [7:0]  d_out;
   logic        gate = 1'b1;
   logic [15:0] cnt_value;
   logic        cnt_done;
   logic [15:0] new_count;
   logic        load;
   logic        cnt_hold;
   logic        out;

   logic [15:0] cnt;
   logic        use_force = 1'b0;
   logic [15:0] forced = 16'h0000;
   int          n_err = 0;
   int          n_checks = 0;

   pit_channel_ctrl #(.CHANNEL_ID(0)) dut (
      .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .d_in(d_in), .d_out(d_out),
      .gate(gate), .cnt_value(cnt_value), .cnt_done(cnt_done), .new_count(new_count),
      .load(load), .cnt_hold(cnt_hold), .out(out)
   );

   always #5 clk = ~clk;

   // Down-counter: hold has priority, then load, then decrement to zero and stop.
   always @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= 16'd0;
      else if (cnt_hold)
         cnt <= cnt;
      else if (load)
         cnt <= new_count;
      else if (cnt != 16'd0)
         cnt <= cnt - 16'd1;
   end
   assign cnt_done  = (cnt == 16'd0);
   assign cnt_value = use_force ? forced : cnt;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      wr = 1'b1; addr = a; d_in = d;
      step(1);
      wr = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a);
      rd = 1'b1; addr = a;
      step(1);
      rd = 1'b0;
   endtask

   initial begin
      // Reset state
      step(2);
      chk("rst_load", 16'(load), 16'd0);
      chk("rst_hold", 16'(cnt_hold), 16'd1);
      chk("rst_out", 16'(out), 16'd0);
      chk("rst_dout", 16'(d_out), 16'h00);
      chk("rst_newcnt", new_count, 16'h0000);
      rst = 1'b1;
      step(1);

      // Mode 0, RW=11, count 5
      bus_write(2'b11, 8'h30);
      chk("m0_ctrl_hold", 16'(cnt_hold), 16'd1);
      bus_write(2'b00, 8'h05);
      chk("m0_lsb_noload", 16'(load), 16'd0);
      bus_write(2'b00, 8'h00);
      $display("m0 load cycle: load=%0d new_count=%h hold=%0d out=%0d", load, new_count, cnt_hold, out);
      chk("m0_load", 16'(load), 16'd1);
      chk("m0_newcnt", new_count, 16'h0005);
      chk("m0_load_hold", 16'(cnt_hold), 16'd0);
      chk("m0_load_out", 16'(out), 16'd0);
      step(1);
      chk("m0_load_pulse", 16'(load), 16'd0);
      step(4);
      chk("m0_out_before", 16'(out), 16'd0);
      step(1);
      chk("m0_out_rise", 16'(out), 16'd1);
      step(3);
      chk("m0_out_held", 16'(out), 16'd1);

      // Mode 2, count 3: reload every 4 clocks
      bus_write(2'b11, 8'h34);
      chk("m2_ctrl_out", 16'(out), 16'd1);
      bus_write(2'b00, 8'h03);
      bus_write(2'b00, 8'h00);
      chk("m2_load", 16'(load), 16'd1);
      step(3);
      chk("m2_out_hi", 16'(out), 16'd1);
      step(1);
      $display("m2 reload 1: load=%0d out=%0d new_count=%h", load, out, new_count);
      chk("m2_out_lo1", 16'(out), 16'd0);
      chk("m2_reload1", 16'(load), 16'd1);
      chk("m2_reload_cnt", new_count, 16'h0003);
      step(1);
      chk("m2_out_back", 16'(out), 16'd1);
      chk("m2_reload_end", 16'(load), 16'd0);
      step(3);
      $display("m2 reload 2: load=%0d out=%0d", load, out);
      chk("m2_out_lo2", 16'(out), 16'd0);
      chk("m2_reload2", 16'(load), 16'd1);

      // Gate pause: mode 0, count 10, gate low 5 cycles
      bus_write(2'b11, 8'h30);
      bus_write(2'b00, 8'h0A);
      bus_write(2'b00, 8'h00);
      step(3);
      gate = 1'b0;
      #1;
      chk("gate_hold", 16'(cnt_hold), 16'd1);
      step(4);
      chk("gate_hold_end", 16'(cnt_hold), 16'd1);
      step(1);
      gate = 1'b1;
      #1;
      chk("gate_release", 16'(cnt_hold), 16'd0);
      step(7);
      chk("gate_out_late", 16'(out), 16'd0);
      step(1);
      $display("gate pause: out=%0d at delayed terminal count", out);
      chk("gate_out_rise", 16'(out), 16'd1);

      // Foreign SC, foreign data port, then mode-0 rewrite
      bus_write(2'b11, 8'h70);
      chk("foreign_out", 16'(out), 16'd1);
      chk("foreign_hold", 16'(cnt_hold), 16'd0);
      bus_write(2'b01, 8'h55);
      chk("foreign_wr_load", 16'(load), 16'd0);
      chk("foreign_wr_cnt", new_count, 16'h000A);
      bus_write(2'b00, 8'h12);
      chk("rewr_lsb_load", 16'(load), 16'd0);
      chk("rewr_lsb_hold", 16'(cnt_hold), 16'd1);
      chk("rewr_lsb_out", 16'(out), 16'd1);
      bus_write(2'b00, 8'h00);
      chk("rewr_load", 16'(load), 16'd1);
      chk("rewr_newcnt", new_count, 16'h0012);
      chk("rewr_out", 16'(out), 16'd0);
      chk("rewr_hold", 16'(cnt_hold), 16'd0);

      // RW=10: single MSB write
      bus_write(2'b11, 8'h20);
      bus_write(2'b00, 8'h02);
      chk("rw10_load", 16'(load), 16'd1);
      chk("rw10_newcnt", new_count, 16'h0200);

      // Reads
      use_force = 1'b1;
      forced = 16'hABCD;
      bus_read(2'b00);
      chk("rd_rw10", 16'(d_out), 16'h00AB);
      bus_write(2'b11, 8'h30);
      bus_read(2'b00);
      $display("read 1: d_out=%h", d_out);
      chk("rd_lsb", 16'(d_out), 16'h00CD);
      bus_read(2'b00);
      $display("read 2: d_out=%h", d_out);
      chk("rd_msb", 16'(d_out), 16'h00AB);
      wr = 1'b1; rd = 1'b1; addr = 2'b01; d_in = 8'h99;
      step(1);
      wr = 1'b0; rd = 1'b0;
      chk("rd_wr_wins", 16'(d_out), 16'h00AB);
      bus_write(2'b11, 8'h00);
      forced = 16'h1234;
      bus_read(2'b00);
`ifdef PIT_COUNT_LATCH_EN
      chk("latch_lsb", 16'(d_out), 16'h00CD);
`else
      chk("live_lsb", 16'(d_out), 16'h0034);
`endif
      bus_read(2'b00);
`ifdef PIT_COUNT_LATCH_EN
      chk("latch_msb", 16'(d_out), 16'h00AB);
`else
      chk("live_msb", 16'(d_out), 16'h0012);
`endif
      bus_read(2'b00);
      chk("rd_after_latch", 16'(d_out), 16'h0034);
      use_force = 1'b0;

      // Mode 2, count 0: reload every 2 cycles
      bus_write(2'b11, 8'h14);
      bus_write(2'b00, 8'h00);
      chk("z_load", 16'(load), 16'd1);
      chk("z_newcnt", new_count, 16'h0000);
      step(1);
      chk("z_gap_load", 16'(load), 16'd0);
      chk("z_gap_out", 16'(out), 16'd1);
      step(1);
      chk("z_reload1", 16'(load), 16'd1);
      chk("z_out_lo", 16'(out), 16'd0);
      step(1);
      chk("z_gap2", 16'(load), 16'd0);
      step(1);
      chk("z_reload2", 16'(load), 16'd1);

      // Async reset after LSB of an RW=11 write
      bus_write(2'b11, 8'h34);
      chk("ar_out_pre", 16'(out), 16'd1);
      bus_write(2'b00, 8'h07);
      rst = 1'b0;
      #1;
      chk("ar_load", 16'(load), 16'd0);
      chk("ar_hold", 16'(cnt_hold), 16'd1);
      chk("ar_out", 16'(out), 16'd0);
      chk("ar_dout", 16'(d_out), 16'h00);
      step(1);
      rst = 1'b1;
      bus_write(2'b00, 8'h00);
      chk("ar_wr_ignored", 16'(load), 16'd0);
      chk("ar_wr_hold", 16'(cnt_hold), 16'd1);
      chk("ar_wr_cnt", new_count, 16'h0000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
